mipi_rx: RTL



---
 rtl/mipi_rx.sv | 100 ++++++++++
 1 files changed

// File: rtl/mipi_rx.sv
// mipi_rx: single-lane D-PHY receiver. It detects LP HS-entry, hunts the HS sync byte,
// and delivers byte-aligned data with valid/sop/eop strobes.
module mipi_rx #(
  parameter int LP_FILT = 3,
  parameter int SYNC_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_lp_p,
  input  logic       d_lp_n,
  input  logic [1:0] d_hs_in,
  output logic       term_en,
  output logic       hs_active,
  output logic [7:0] d_out,
  output logic       d_valid,
  output logic       d_sop,
  output logic       d_eop,
  output logic       sync_err
);
  typedef enum logic [2:0] {WAIT_STOP, STOP, HS_RQST, HS_SYNC, HS_DATA} state_t;
  state_t state, nxt;
  logic [1:0] s1, s2, cand, lp;
  logic [3:0] cnt, run;
  logic [9:0] sr, sr_nxt;
  logic [7:0] tcnt;
  logic [1:0] pc;
  logic off, first, hit, err, eop, emit, m0, m1, hs;
  assign term_en = hs;
  assign hs_active = hs;
  always_comb begin
    run = s2 == cand ? cnt + 4'd1 : 4'd1;
    sr_nxt = {d_hs_in[1], d_hs_in[0], sr[9:2]};
    m0 = sr_nxt[9:2] == 8'hB8;
    m1 = sr_nxt[8:1] == 8'hB8;
    hs = state == HS_SYNC || state == HS_DATA;
    emit = state == HS_DATA && pc == 2'd3;
    nxt = state;
    hit = 1'b0;
    err = 1'b0;
    eop = 1'b0;
    case (state)
      WAIT_STOP: nxt = lp == 2'b11 ? STOP : WAIT_STOP;
      STOP:      nxt = lp == 2'b01 ? HS_RQST : lp == 2'b11 ? STOP : WAIT_STOP;
      HS_RQST:   nxt = lp == 2'b00 ? HS_SYNC : lp == 2'b11 ? STOP : lp == 2'b10 ? WAIT_STOP : HS_RQST;
      HS_SYNC:
        if (lp == 2'b11) begin
          err = 1'b1;
          nxt = STOP;
        end else if (tcnt >= 8'd3 && (m0 || m1)) begin
          hit = 1'b1;
          nxt = HS_DATA;
        end else if (tcnt == 8'(SYNC_TIMEOUT - 1)) begin
          err = 1'b1;
          nxt = WAIT_STOP;
        end
      HS_DATA:
        if (lp == 2'b11) begin
          eop = 1'b1;
          nxt = STOP;
        end
      default: nxt = WAIT_STOP;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      cand <= '0;
      cnt <= '0;
      lp <= '0;
      state <= WAIT_STOP;
      sr <= '0;
      tcnt <= '0;
      pc <= '0;
      off <= 1'b0;
      first <= 1'b0;
      d_out <= '0;
      d_valid <= 1'b0;
      d_sop <= 1'b0;
      d_eop <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      s1 <= {d_lp_p, d_lp_n};
      s2 <= s1;
      cand <= s2;
      cnt <= s2 == lp ? 4'd0 : run;
      if (s2 != lp && run == 4'(LP_FILT)) lp <= s2;
      state <= nxt;
      sr <= hs ? sr_nxt : '0;
      tcnt <= state == HS_SYNC ? tcnt + 8'd1 : 8'd0;
      pc <= hit ? 2'd0 : state == HS_DATA ? pc + 2'd1 : pc;
      if (hit) off <= !m0;
      first <= hit | (first & !emit);
      d_valid <= emit;
      d_sop <= emit & first;
      d_eop <= eop;
      sync_err <= err;
      if (emit) d_out <= off ? sr_nxt[8:1] : sr_nxt[9:2];
    end
endmodule
